// File: rtl/fp_mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// fp_mult_arb_pkg
// Shared definitions for the fixed-point multiplier arbiter and the NISC
// decode logic that addresses its requester ports.
//   fp_req_id_t  : requester index type, wide enough for FP_REQS_MAX ports
//   FP_REQS_MAX  : largest supported requester count
//   FP_MULT_LAT  : handshake-to-response latency in cycles
//   rr_pick()    : round-robin winner search starting after 'last'
// -----------------------------------------------------------------------------
package fp_mult_arb_pkg;

  localparam int FP_REQS_MAX = 8;
  localparam int FP_MULT_LAT = 2;

  typedef logic [$clog2(FP_REQS_MAX)-1:0] fp_req_id_t;

  // Searches last+1, last+2, ... with wrap modulo FP_REQS_MAX. Callers with
  // fewer requesters zero-pad 'valid'; since the padded bits never win, the
  // visiting order of real requesters equals a search modulo their count.
  // When nothing is valid the result is 'last' and the caller ignores it.
  function automatic fp_req_id_t rr_pick(input logic [FP_REQS_MAX-1:0] valid,
                                         input fp_req_id_t             last);
    fp_req_id_t idx;
    fp_req_id_t pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= FP_REQS_MAX; i++) begin
      idx = last + fp_req_id_t'(i);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fp_mult.sv
// -----------------------------------------------------------------------------
// fp_mult
// Combinational signed fixed-point multiplier. Result keeps the operand
// format: product bits [n+f-1:f], i.e. truncation toward minus infinity with
// wrap-around on overflow.
//   a, b : signed operands, n bits, f fractional bits
//   y    : truncated product, n bits
// -----------------------------------------------------------------------------
module fp_mult #(
  parameter int n = 8,
  parameter int f = 7
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] y
);

  logic signed [2*n-1:0] w_prod;
  logic                  w_unused_bits;

  assign w_prod = $signed(a) * $signed(b);
  assign y      = w_prod[n+f-1:f];

  // Bits outside the result window are deliberately discarded.
  assign w_unused_bits = ^{w_prod[2*n-1:n+f], w_prod[f-1:0]};

endmodule

// File: rtl/fp_mult_arb.sv
// -----------------------------------------------------------------------------
// fp_mult_arb
// Shares one fp_mult between REQS requesters. Operands are captured into S1,
// multiplied between S1 and S2, and the S2 result is returned to the
// requester that issued it. One multiply enters per cycle at most.
// Build option: FP_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority
// instead of the default round-robin.
//   clk, n_reset : clock, asynchronous active-low reset
//   req_valid/req_ready/req_a/req_b : per-requester operand channel
//   rsp_valid/rsp_ready/rsp_data    : per-requester result channel (shared data)
//   busy         : either pipeline stage occupied
//
// Handshake: a transfer happens on a rising edge where valid and ready of the
// same channel are both high. req_ready depends combinationally on req_valid
// (at most one bit set). rsp_valid never depends on rsp_ready; once raised it
// stays high with stable rsp_data until the owner's rsp_ready is sampled high.
// -----------------------------------------------------------------------------
module fp_mult_arb
  import fp_mult_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int F    = 7,
  parameter int REQS = 4
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic [REQS-1:0]          req_valid,
  output logic [REQS-1:0]          req_ready,
  input  logic [REQS-1:0][N-1:0]   req_a,
  input  logic [REQS-1:0][N-1:0]   req_b,
  output logic [REQS-1:0]          rsp_valid,
  input  logic [REQS-1:0]          rsp_ready,
  output logic [N-1:0]             rsp_data,
  output logic                     busy
);

  localparam int ID_W = $clog2(REQS);

  // Pipeline state
  logic            r_s1_v;
  logic [ID_W-1:0] r_s1_id;
  logic [N-1:0]    r_s1_a;
  logic [N-1:0]    r_s1_b;
  logic            r_s2_v;
  logic [ID_W-1:0] r_s2_id;
  logic [N-1:0]    r_s2_data;

  logic            w_s2_hold;
  logic            w_s1_adv;
  logic            w_s1_free;
  logic            w_any_valid;
  logic            w_grant;
  logic [ID_W-1:0] w_grant_id;
  logic [N-1:0]    w_mult_y;

  // Stall chain: S2 holds until its owner accepts; S1 moves when S2 does not
  // hold, which lets retire, advance and a new grant share one cycle.
  assign w_s2_hold   = r_s2_v & ~rsp_ready[r_s2_id];
  assign w_s1_adv    = r_s1_v & ~w_s2_hold;
  assign w_s1_free   = ~r_s1_v | w_s1_adv;
  assign w_any_valid = |req_valid;
  // Gated by n_reset so no requester sees ready while reset is asserted.
  assign w_grant     = n_reset & w_s1_free & w_any_valid;

`ifdef FP_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest index wins; no rotation state exists in this build.
  always_comb begin
    w_grant_id = '0;
    for (int i = REQS - 1; i >= 0; i--) begin
      if (req_valid[i]) w_grant_id = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] r_last_id;

  assign w_grant_id = ID_W'(rr_pick(FP_REQS_MAX'(req_valid), fp_req_id_t'(r_last_id)));

  // Reset to REQS-1 so that requester 0 is searched first.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_last_id <= ID_W'(REQS - 1);
    end else if (w_grant) begin
      r_last_id <= w_grant_id;
    end
  end
`endif

  assign req_ready = w_grant ? (REQS'(1) << w_grant_id) : '0;

  // S1: operand register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_s1_v  <= 1'b0;
      r_s1_id <= '0;
      r_s1_a  <= '0;
      r_s1_b  <= '0;
    end else if (w_s1_free) begin
      r_s1_v <= w_any_valid;
      if (w_any_valid) begin
        r_s1_id <= w_grant_id;
        r_s1_a  <= req_a[w_grant_id];
        r_s1_b  <= req_b[w_grant_id];
      end
    end
  end

  fp_mult #(
    .n (N),
    .f (F)
  ) u_fp_mult (
    .a (r_s1_a),
    .b (r_s1_b),
    .y (w_mult_y)
  );

  // S2: result register; id and data are frozen while held.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_s2_v    <= 1'b0;
      r_s2_id   <= '0;
      r_s2_data <= '0;
    end else if (w_s1_adv) begin
      r_s2_v    <= 1'b1;
      r_s2_id   <= r_s1_id;
      r_s2_data <= w_mult_y;
    end else if (!w_s2_hold) begin
      r_s2_v <= 1'b0;
    end
  end

  assign rsp_valid = r_s2_v ? (REQS'(1) << r_s2_id) : '0;
  assign rsp_data  = r_s2_data;
  assign busy      = r_s1_v | r_s2_v;

endmodule

// File: tb/tb_fp_mult_arb.sv
// -----------------------------------------------------------------------------
// tb_fp_mult_arb
// Self-checking bench for fp_mult_arb (N=8, F=7, REQS=4). Inputs change on the
// falling edge; outputs are compared one time unit later, every cycle, against
// a transaction-queue model of the arbiter. Table vectors and hand-written
// sequences cover the documented corner cases.
// -----------------------------------------------------------------------------
module tb_fp_mult_arb;
  import fp_mult_arb_pkg::*;

  localparam int N    = 8;
  localparam int F    = 7;
  localparam int REQS = 4;

  // ---------------- clock / reset ----------------
  logic                   clk;
  logic                   n_reset;
  logic [REQS-1:0]        req_valid;
  logic [REQS-1:0]        req_ready;
  logic [REQS-1:0][N-1:0] req_a;
  logic [REQS-1:0][N-1:0] req_b;
  logic [REQS-1:0]        rsp_valid;
  logic [REQS-1:0]        rsp_ready;
  logic [N-1:0]           rsp_data;
  logic                   busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fp_mult_arb #(
    .N    (N),
    .F    (F),
    .REQS (REQS)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // ---------------- scoreboard / reference model ----------------
  // In-flight operations in issue order: expected result, owner, cycles since accept.
  logic [N-1:0] exp_q[$];
  int           id_q[$];
  int           age_q[$];
  int           m_last;

  int n_tests;
  int n_fail;

  logic [REQS-1:0] obs_ready;
  logic [REQS-1:0] obs_rvalid;
  logic [N-1:0]    obs_data;
  logic            obs_busy;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [REQS-1:0] onehot(input int i);
    logic [REQS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Q-format product: floor(a*b / 2^F), keep the low N bits.
  function automatic logic [N-1:0] model_mult(input logic [N-1:0] a, input logic [N-1:0] b);
    int          sa;
    int          sb;
    logic [31:0] p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p  = 32'((sa * sb) >>> F);
    return p[N-1:0];
  endfunction

  function automatic int pick_winner(input logic [REQS-1:0] v);
    int w;
    w = -1;
`ifdef FP_ARB_FIXED_PRIO_EN
    for (int i = REQS - 1; i >= 0; i--) if (v[i]) w = i;
`else
    for (int k = REQS; k >= 1; k--) if (v[(m_last + k) % REQS]) w = (m_last + k) % REQS;
`endif
    return w;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    id_q.delete();
    age_q.delete();
    m_last = REQS - 1;
  endtask

  // One clock cycle: called at a falling edge with inputs already set.
  task automatic cycle();
    logic            presented;
    logic            free;
    logic [REQS-1:0] e_ready;
    logic [REQS-1:0] e_rvalid;
    int              win;
    #1;
    presented = (id_q.size() > 0) && (age_q[0] >= FP_MULT_LAT);
    e_rvalid  = presented ? onehot(id_q[0]) : '0;
    free      = (id_q.size() < 2) || (presented && rsp_ready[id_q[0]]);
    win       = pick_winner(req_valid);
    e_ready   = (free && (req_valid != '0)) ? onehot(win) : '0;
    check("req_ready", int'(req_ready), int'(e_ready));
    check("rsp_valid", int'(rsp_valid), int'(e_rvalid));
    check("busy", int'(busy), int'(id_q.size() > 0));
    if (presented) check("rsp_data", int'(rsp_data), int'(exp_q[0]));
    obs_ready  = req_ready;
    obs_rvalid = rsp_valid;
    obs_data   = rsp_data;
    obs_busy   = busy;
    if (presented && rsp_ready[id_q[0]]) begin
      void'(exp_q.pop_front());
      void'(id_q.pop_front());
      void'(age_q.pop_front());
    end
    if (e_ready != '0) begin
      exp_q.push_back(model_mult(req_a[win], req_b[win]));
      id_q.push_back(win);
      age_q.push_back(0);
      m_last = win;
    end
    foreach (age_q[k]) age_q[k]++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drain(input int n);
    req_valid = '0;
    rsp_ready = '1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] y;
  } vec_t;

  vec_t vecs[9];
  int   exp_grant[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc_total;
    int ret_total;
    logic [N-1:0] held;
    logic [N-1:0] x_a;
    logic [N-1:0] x_b;

    n_tests = 0;
    n_fail  = 0;
    model_clear();

    vecs[0] = '{a: 8'h40, b: 8'h40, y: 8'h20};
    vecs[1] = '{a: 8'h40, b: 8'hC0, y: 8'hE0};
    vecs[2] = '{a: 8'h80, b: 8'h80, y: 8'h80};
    vecs[3] = '{a: 8'h7F, b: 8'h01, y: 8'h00};
    vecs[4] = '{a: 8'hC0, b: 8'hC0, y: 8'h20};
    vecs[5] = '{a: 8'h7F, b: 8'h7F, y: 8'h7E};
    vecs[6] = '{a: 8'hFF, b: 8'h01, y: 8'hFF};
    vecs[7] = '{a: 8'h80, b: 8'h7F, y: 8'h81};
    vecs[8] = '{a: 8'h00, b: 8'h55, y: 8'h00};

    for (int i = 0; i < 8; i++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
      exp_grant[i] = 0;
`else
      exp_grant[i] = i % REQS;
`endif
    end

    // Reset state, with every requester asking.
    n_reset   = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    req_a     = '0;
    req_b     = '0;
    @(negedge clk);
    #1;
    check("reset_req_ready", int'(req_ready), 0);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_data", int'(rsp_data), 0);
    check("reset_busy", int'(busy), 0);
    n_reset = 1'b1;

    // Contention: all requesters valid continuously.
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < REQS; r++) begin
        req_a[r] = N'($urandom);
        req_b[r] = N'($urandom);
      end
      req_valid = '1;
      cycle();
      check("contention_grant", int'(obs_ready), int'(onehot(exp_grant[c])));
    end
    drain(4);

    // Table vectors, one isolated operation each.
    for (int i = 0; i < 9; i++) begin
      int r;
      r         = i % REQS;
      req_valid = onehot(r);
      req_a[r]  = vecs[i].a;
      req_b[r]  = vecs[i].b;
      cycle();
      check("vec_accept", int'(obs_ready), int'(onehot(r)));
      check("vec_idle_busy", int'(obs_busy), 0);
      req_valid = '0;
      cycle();
      check("vec_t1_busy", int'(obs_busy), 1);
      check("vec_t1_rsp_valid", int'(obs_rvalid), 0);
      cycle();
      check("vec_t2_rsp_valid", int'(obs_rvalid), int'(onehot(r)));
      check("vec_t2_rsp_data", int'(obs_data), int'(vecs[i].y));
      check("vec_t2_busy", int'(obs_busy), 1);
    end
    drain(2);

    // Backpressure on requester 1 during a stream.
    rsp_ready    = '1;
    rsp_ready[1] = 1'b0;
    acc          = 0;
    acc_total    = 0;
    ret_total    = 0;
    held         = '0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'b0010;
      req_a[1]  = N'($urandom);
      req_b[1]  = N'($urandom);
      cycle();
      if (obs_ready[1]) acc++;
      if (c == 2) held = obs_data;
      if (c > 2) check("bp_data_stable", int'(obs_data), int'(held));
    end
    check("bp_accepts_while_held", acc, 2);
    check("bp_rsp_valid_held", int'(obs_rvalid), int'(onehot(1)));
    acc_total = acc;
    rsp_ready = '1;
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 3) ? 4'b0010 : 4'b0000;
      req_a[1]  = N'($urandom);
      req_b[1]  = N'($urandom);
      cycle();
      if (obs_ready[1]) acc_total++;
      if (obs_rvalid[1]) ret_total++;
    end
    check("bp_no_loss", ret_total, acc_total);
    check("bp_drained", int'(obs_busy), 0);

    // Mixed retire: req 2 held while req 3 streams.
    rsp_ready    = '1;
    rsp_ready[2] = 1'b0;
    req_valid    = 4'b0100;
    req_a[2]     = 8'h30;
    req_b[2]     = 8'h50;
    cycle();
    x_a       = 8'hA0;
    x_b       = 8'h60;
    req_valid = 4'b1000;
    req_a[3]  = x_a;
    req_b[3]  = x_b;
    cycle();
    check("mixed_first_accept", int'(obs_ready), int'(onehot(3)));
    req_a[3] = 8'h11;
    req_b[3] = 8'h22;
    cycle();
    check("mixed_full_no_ready", int'(obs_ready), 0);
    check("mixed_req2_held", int'(obs_rvalid), int'(onehot(2)));
    rsp_ready[2] = 1'b1;
    cycle();
    check("mixed_retire_and_accept", int'(obs_ready), int'(onehot(3)));
    check("mixed_req2_retires", int'(obs_rvalid), int'(onehot(2)));
    req_valid = '0;
    cycle();
    check("mixed_order_id", int'(obs_rvalid), int'(onehot(3)));
    check("mixed_order_data", int'(obs_data), int'(model_mult(x_a, x_b)));
    drain(3);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      req_valid = REQS'($urandom_range(0, (1 << REQS) - 1));
      for (int r = 0; r < REQS; r++) begin
        req_a[r]     = N'($urandom);
        req_b[r]     = N'($urandom);
        rsp_ready[r] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    drain(4);

    // Reset with both stages full.
    rsp_ready = '0;
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) cycle();
    check("prereset_full", int'(obs_busy), 1);
    n_reset   = 1'b0;
    req_valid = '1;
    #1;
    check("midreset_rsp_valid", int'(rsp_valid), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_req_ready", int'(req_ready), 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    n_reset   = 1'b1;
    rsp_ready = '1;
    req_valid = '1;
    cycle();
    check("postreset_first_grant", int'(obs_ready), int'(onehot(0)));
    drain(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
